instr_mem_pipelined: RTL and testbench

//   Parametrised synchronous instruction memory for the MIPS core. Replaces the async-read ROM.

---
 rtl/instr_mem_pipelined.sv | 140 ++++++++++++++
 tb/tb_instr_mem_pipelined.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_pipelined.sv
// rtl/instr_mem_pipelined.sv - synchronous instruction memory with valid/ready fetch, flush, loader and hardware clear
module instr_mem_pipelined #(
    parameter int                 DATA_W       = 32,
    parameter int                 DEPTH        = 1024,
    parameter logic [31:0]        BASE_ADDR    = 32'h0000_0000,
    parameter int                 READ_LATENCY = 1,
    parameter logic [DATA_W-1:0]  NOP_WORD     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              flush,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [31:0]       rsp_addr,
    output logic [1:0]        rsp_fault,
    input  logic              load_en,
    input  logic [31:0]       load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err,
    output logic              init_done
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
    localparam int          LAT  = READ_LATENCY;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              run;
    logic              accept;
    logic [31:0]       req_off;
    logic [31:0]       load_off;
    logic [1:0]        req_fault;
    logic              load_bad;
    logic [DATA_W-1:0] rd_word;

    logic [LAT-1:0]    s_valid_q;
    logic [DATA_W-1:0] s_instr_q [LAT];
    logic [31:0]       s_addr_q  [LAT];
    logic [1:0]        s_fault_q [LAT];
    logic              load_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_CLEAR;
        endcase
    end

    assign run       = (state_q == S_RUN);
    assign init_done = run;
    assign req_ready = run & ~load_en;
    assign accept    = req_valid & req_ready;

    // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land out of range.
    assign req_off  = req_addr - BASE_ADDR;
    assign load_off = load_addr - BASE_ADDR;

    always_comb begin
        req_fault = 2'b00;
        if (req_addr[1:0] != 2'b00) begin
            req_fault = 2'b01;
        end else if ({1'b0, req_off} >= SPAN) begin
            req_fault = 2'b10;
        end
    end

    assign load_bad = (load_addr[1:0] != 2'b00) || ({1'b0, load_off} >= SPAN);
    assign rd_word  = mem_q[req_off[AW+1:2]];

    // Single write port shared by the clear sweep and the loader.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem_q[cnt_q] <= NOP_WORD;
        end else if (load_en && !load_bad) begin
            mem_q[load_off[AW+1:2]] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid_q  <= '0;
            load_err_q <= 1'b0;
            for (int k = 0; k < LAT; k++) begin
                s_instr_q[k] <= NOP_WORD;
                s_addr_q[k]  <= '0;
                s_fault_q[k] <= 2'b00;
            end
        end else begin
            load_err_q   <= load_en & run & load_bad;
            s_valid_q[0] <= accept;
            if (accept) begin
                s_instr_q[0] <= (req_fault != 2'b00) ? NOP_WORD : rd_word;
                s_addr_q[0]  <= req_addr;
                s_fault_q[0] <= req_fault;
            end
            // Payload only advances with a surviving valid so rsp_* hold between responses.
            for (int k = 1; k < LAT; k++) begin
                s_valid_q[k] <= s_valid_q[k-1] & ~flush;
                if (s_valid_q[k-1] && !flush) begin
                    s_instr_q[k] <= s_instr_q[k-1];
                    s_addr_q[k]  <= s_addr_q[k-1];
                    s_fault_q[k] <= s_fault_q[k-1];
                end
            end
        end
    end

    assign rsp_valid = s_valid_q[LAT-1];
    assign rsp_instr = s_instr_q[LAT-1];
    assign rsp_addr  = s_addr_q[LAT-1];
    assign rsp_fault = s_fault_q[LAT-1];
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_instr_mem_pipelined.sv
// tb/tb_instr_mem_pipelined.sv - scoreboard bench for instr_mem_pipelined
module tb_instr_mem_pipelined;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam int          LAT    = 3;
    localparam logic [31:0] NOP    = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_fault;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        load_err;
    logic        init_done;

    instr_mem_pipelined #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE),
        .READ_LATENCY(LAT), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .load_err(load_err), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  fault;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [DEPTH];
    bit          run_m = 0;
    int          rem_m = DEPTH;
    bit          lerr_exp = 0;
    bit          armed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [1:0] fault_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (a[1:0] != 2'b00) return 2'b01;
        if (off >= 32'(4 * DEPTH)) return 2'b10;
        return 2'b00;
    endfunction

    // Drops every response that would have been presented at or after edge e.
    task automatic drop_from(input int e);
        while (sb.size() > 0 && sb[$].due >= e) void'(sb.pop_back());
    endtask

    task automatic step(input logic rst, input logic rv, input logic [31:0] ra, input logic fl,
                        input logic le, input logic [31:0] la, input logic [31:0] ld);
        int          e;
        logic [1:0]  f;
        exp_t        x;
        @(negedge clk);
        if (armed) begin
            chk("load_err", 64'(load_err), 64'(lerr_exp));
            chk("init_done", 64'(init_done), 64'(run_m));
        end
        reset = rst; req_valid = rv; req_addr = ra; flush = fl;
        load_en = le; load_addr = la; load_data = ld;
        #1;
        if (armed && !rst) chk("req_ready", 64'(req_ready), 64'(run_m && !le));
        e = cyc + 1;
        if (rst) begin
            drop_from(e);
            run_m = 0; rem_m = DEPTH; lerr_exp = 0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
        end else begin
            if (fl) drop_from(e);
            if (run_m && !le && rv) begin
                f = fault_of(ra);
                x.due   = e + LAT - 1;
                x.addr  = ra;
                x.fault = f;
                x.instr = (f != 2'b00) ? NOP : mem_m[(ra - BASE) >> 2];
                sb.push_back(x);
            end
            lerr_exp = run_m && le && (fault_of(la) != 2'b00);
            if (run_m && le && fault_of(la) == 2'b00) mem_m[(la - BASE) >> 2] = ld;
            if (!run_m) begin
                rem_m--;
                if (rem_m == 0) run_m = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, '0);
    endtask

    task automatic fetch(input logic [31:0] a);
        step(0, 1, a, 0, 0, '0, '0);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        step(0, 0, '0, 0, 1, a, d);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return $urandom;
            1:       return BASE - 32'(4 * $urandom_range(1, 3));
            2:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1))
                            + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
        endcase
    endfunction

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due < cyc) begin
                checks++; errors++;
                $display("FAIL rsp_missing at cycle %0d: no response, expected addr %h due %0d",
                         cyc, sb[0].addr, sb[0].due);
                void'(sb.pop_front());
            end
            if (rsp_valid === 1'b1) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected at cycle %0d: got addr %h, expected no response",
                             cyc, rsp_addr);
                end else begin
                    chk("rsp_instr", 64'(rsp_instr), 64'(sb[0].instr));
                    chk("rsp_addr", 64'(rsp_addr), 64'(sb[0].addr));
                    chk("rsp_fault", 64'(rsp_fault), 64'(sb[0].fault));
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        step(1, 0, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_instr", 64'(rsp_instr), 64'(NOP));
        chk("rst_rsp_addr", 64'(rsp_addr), 64'd0);
        chk("rst_rsp_fault", 64'(rsp_fault), 64'd0);
        chk("rst_load_err", 64'(load_err), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        armed = 1;
        // Clear sweep: fetches and loads must be ignored until init_done.
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 3) load(BASE, 32'h1234_5678);
            else fetch(BASE + 32'h3C);
        end
        fetch(BASE + 32'h3C);
        load(BASE + 32'h0, 32'h2008_000A);
        load(BASE + 32'h4, 32'h2009_0005);
        fetch(BASE + 32'h0);
        fetch(BASE + 32'h4);
        fetch(BASE + 32'h6);
        fetch(BASE + 32'(4 * DEPTH));
        fetch(BASE - 32'h4);
        idle(LAT + 1);
        fetch(BASE + 32'h0);
        fetch(BASE + 32'h4);
        fetch(BASE + 32'h8);
        step(0, 1, BASE + 32'h20, 1, 0, '0, '0);
        idle(LAT + 1);
        step(0, 1, BASE + 32'h8, 0, 1, BASE + 32'h8, 32'hCAFE_0008);
        fetch(BASE + 32'h8);
        load(BASE + 32'hABC, 32'hBAD0_0001);
        load(BASE + 32'h2, 32'hBAD0_0002);
        fetch(BASE + 32'h2);
        idle(LAT + 1);
        load(BASE + 32'hC, 32'h0BAD_F00D);
        fetch(BASE + 32'hC);
        fetch(BASE + 32'h0);
        step(1, 0, '0, 0, 0, '0, '0);
        idle(DEPTH + 2);
        fetch(BASE + 32'hC);
        idle(LAT + 1);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, rand_addr(),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0, rand_addr(), $urandom);
        end
        idle(DEPTH + LAT + 4);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
